// File: rtl/dmem_bridge.sv
// dmem_bridge: turns core loads/stores into handshaked word-bus transactions.
// Builds byte enables and lane-replicated store data, extends load data, stalls
// the core while the bus is busy, aborts after a bounded wait and flags
// misaligned accesses without touching the bus.
module dmem_bridge #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_re,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [2:0]  cpu_dmtype,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        misalign,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ready
);

   // Counter only has to reach TIMEOUT-1.
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

   state_t        state_reg, state_next;
   logic          bus_req_reg, bus_req_next;
   logic          bus_we_reg, bus_we_next;
   logic [31:0]   bus_addr_reg, bus_addr_next;
   logic [3:0]    bus_be_reg, bus_be_next;
   logic [31:0]   bus_wdata_reg, bus_wdata_next;
   logic [1:0]    off_reg, off_next;
   logic [2:0]    dmtype_reg, dmtype_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [31:0]   rdata_reg, rdata_next;
   logic          err_reg, err_next;

   // Access-size decode of the incoming request; codes 101-111 act as word.
   logic        is_half, is_byte, is_access, is_misaligned;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;

   assign is_half       = (cpu_dmtype == 3'b001) || (cpu_dmtype == 3'b010);
   assign is_byte       = (cpu_dmtype == 3'b011) || (cpu_dmtype == 3'b100);
   assign is_access     = cpu_re | cpu_we;
   assign is_misaligned = is_half ? cpu_addr[0] : (!is_byte && (cpu_addr[1:0] != 2'b00));

   // Byte enables follow the byte offset and access size.
   always_comb begin
      be_new = 4'b1111;
      if (is_byte) begin
         be_new = 4'b0001 << cpu_addr[1:0];
      end else if (is_half) begin
         be_new = cpu_addr[1] ? 4'b1100 : 4'b0011;
      end
   end

   // Store data is replicated across lanes so the enabled lane always holds it.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wlane
         assign wdata_new[8*gi +: 8] = is_byte ? cpu_wdata[7:0] :
                                       is_half ? cpu_wdata[8*(gi%2) +: 8] :
                                                 cpu_wdata[8*gi +: 8];
      end
   endgenerate

   // Read lanes, selected later by the latched byte offset.
   logic [7:0]  rd_byte [4];
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_value;

   generate
      for (gi = 0; gi < 4; gi++) begin : g_rlane
         assign rd_byte[gi] = bus_rdata[8*gi +: 8];
      end
   endgenerate

   assign sel_byte = rd_byte[off_reg];
   assign sel_half = off_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];

   // Lane extraction and sign/zero extension of the returned word; stores yield 0.
   always_comb begin
      load_value = bus_rdata;
      case (dmtype_reg)
         3'b001:  load_value = {{16{sel_half[15]}}, sel_half};
         3'b010:  load_value = {16'h0000, sel_half};
         3'b011:  load_value = {{24{sel_byte[7]}}, sel_byte};
         3'b100:  load_value = {24'h000000, sel_byte};
         default: load_value = bus_rdata;
      endcase
      if (bus_we_reg) begin
         load_value = 32'h0000_0000;
      end
   end

   // Next-state and combinational core-side outputs for the IDLE/REQ/DONE sequence.
   always_comb begin
      state_next     = state_reg;
      bus_req_next   = bus_req_reg;
      bus_we_next    = bus_we_reg;
      bus_addr_next  = bus_addr_reg;
      bus_be_next    = bus_be_reg;
      bus_wdata_next = bus_wdata_reg;
      off_next       = off_reg;
      dmtype_next    = dmtype_reg;
      cnt_next       = cnt_reg;
      rdata_next     = rdata_reg;
      err_next       = err_reg;
      cpu_stall      = 1'b0;
      misalign       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (is_access) begin
               if (is_misaligned) begin
                  misalign = 1'b1;
               end else begin
                  cpu_stall      = 1'b1;
                  state_next     = ST_REQ;
                  bus_req_next   = 1'b1;
                  bus_we_next    = cpu_we;
                  bus_addr_next  = {cpu_addr[31:2], 2'b00};
                  bus_be_next    = be_new;
                  bus_wdata_next = wdata_new;
                  off_next       = cpu_addr[1:0];
                  dmtype_next    = cpu_dmtype;
                  cnt_next       = '0;
               end
            end
         end
         ST_REQ: begin
            cpu_stall = 1'b1;
            if (bus_ready) begin
               rdata_next   = load_value;
               err_next     = 1'b0;
               cnt_next     = '0;
               bus_req_next = 1'b0;
               state_next   = ST_DONE;
            end else if (cnt_reg == CNT_LAST) begin
               rdata_next   = 32'h0000_0000;
               err_next     = 1'b1;
               cnt_next     = '0;
               bus_req_next = 1'b0;
               state_next   = ST_DONE;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ST_DONE: begin
            rdata_next = 32'h0000_0000;
            err_next   = 1'b0;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         bus_req_reg   <= 1'b0;
         bus_we_reg    <= 1'b0;
         bus_addr_reg  <= 32'h0000_0000;
         bus_be_reg    <= 4'b0000;
         bus_wdata_reg <= 32'h0000_0000;
         off_reg       <= 2'b00;
         dmtype_reg    <= 3'b000;
         cnt_reg       <= '0;
         rdata_reg     <= 32'h0000_0000;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         bus_req_reg   <= bus_req_next;
         bus_we_reg    <= bus_we_next;
         bus_addr_reg  <= bus_addr_next;
         bus_be_reg    <= bus_be_next;
         bus_wdata_reg <= bus_wdata_next;
         off_reg       <= off_next;
         dmtype_reg    <= dmtype_next;
         cnt_reg       <= cnt_next;
         rdata_reg     <= rdata_next;
         err_reg       <= err_next;
      end
   end

   assign bus_req   = bus_req_reg;
   assign bus_we    = bus_we_reg;
   assign bus_addr  = bus_addr_reg;
   assign bus_be    = bus_be_reg;
   assign bus_wdata = bus_wdata_reg;
   assign cpu_rdata = rdata_reg;
   assign bus_err   = err_reg;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: scoreboard bench for dmem_bridge. The driver pushes expected
// responses computed from access-size arithmetic; a negedge monitor checks them.
module tb_dmem_bridge;

   localparam int TO_A = 255;
   localparam int TO_B = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        cpu_re, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata;
   logic [2:0]  cpu_dmtype;
   logic [31:0] cpu_rdata;
   logic        cpu_stall, misalign, bus_err, bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;
   logic        bus_ready;

   logic        b_re, b_we;
   logic [31:0] b_addr, b_wdata;
   logic [2:0]  b_dmtype;
   logic [31:0] b_cpu_rdata;
   logic        b_cpu_stall, b_misalign, b_bus_err, b_bus_req, b_bus_we;
   logic [31:0] b_bus_addr, b_bus_wdata, b_rdata;
   logic [3:0]  b_bus_be;
   logic        b_ready;

   dmem_bridge #(.TIMEOUT(TO_A)) dut (
      .clk(clk), .reset(reset), .cpu_re(cpu_re), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_dmtype(cpu_dmtype),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .misalign(misalign),
      .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
   );

   dmem_bridge #(.TIMEOUT(TO_B)) dut_to (
      .clk(clk), .reset(reset), .cpu_re(b_re), .cpu_we(b_we),
      .cpu_addr(b_addr), .cpu_wdata(b_wdata), .cpu_dmtype(b_dmtype),
      .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall), .misalign(b_misalign),
      .bus_err(b_bus_err), .bus_req(b_bus_req), .bus_we(b_bus_we), .bus_addr(b_bus_addr),
      .bus_be(b_bus_be), .bus_wdata(b_bus_wdata), .bus_rdata(b_rdata), .bus_ready(b_ready)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          stall;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int size_of(input logic [2:0] t);
      if (t == 3'd3 || t == 3'd4) return 1;
      if (t == 3'd1 || t == 3'd2) return 2;
      return 4;
   endfunction

   function automatic logic misaligned_m(input logic [31:0] a, input logic [2:0] t);
      return (a % size_of(t)) != 0;
   endfunction

   function automatic logic [3:0] be_m(input logic [31:0] a, input logic [2:0] t);
      int sz = size_of(t);
      if (sz == 4) return 4'hF;
      return 4'(((1 << sz) - 1) << a[1:0]);
   endfunction

   function automatic logic [31:0] wdata_m(input logic [31:0] w, input logic [2:0] t);
      int sz = size_of(t);
      if (sz == 1) return {4{w[7:0]}};
      if (sz == 2) return {2{w[15:0]}};
      return w;
   endfunction

   function automatic logic [31:0] load_m(input logic [31:0] rd, input logic [31:0] a, input logic [2:0] t);
      int          sz   = size_of(t);
      int          bits = 8 * sz;
      logic [31:0] v;
      logic [31:0] mask;
      if (sz == 4) return rd;
      v    = rd >> (8 * a[1:0]);
      mask = (32'h1 << bits) - 32'h1;
      v    = v & mask;
      if ((t == 3'd1 || t == 3'd3) && v[bits-1]) v = v | ~mask;
      return v;
   endfunction

   // ---------------- driver ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         cpu_re    = 1'b0;
         cpu_we    = 1'b0;
         cpu_addr  = $urandom;
         bus_ready = 1'($urandom_range(0, 1));
         bus_rdata = $urandom;
      end
   endtask

   task automatic access(input logic re, input logic we, input logic [31:0] a,
                         input logic [31:0] w, input logic [2:0] t, input int nlow,
                         input logic [31:0] rd);
      exp_t e;
      @(posedge clk); #1;
      cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wdata = w; cpu_dmtype = t;
      bus_ready = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      if (misaligned_m(a, t)) begin
         #1;
         check("misalign_flag", misalign, 1);
         check("misalign_stall", cpu_stall, 0);
         check("misalign_busreq", bus_req, 0);
         $display("[TB] misaligned addr=%h type=%0d", a, t);
         return;
      end
      e.addr  = {a[31:2], 2'b00};
      e.be    = be_m(a, t);
      e.we    = we;
      e.wdata = wdata_m(w, t);
      e.err   = (nlow >= TO_A);
      e.rdata = (e.err || we) ? 32'h0 : load_m(rd, a, t);
      e.stall = (nlow >= TO_A) ? TO_A + 1 : nlow + 2;
      q.push_back(e);
      #1;
      check("idle_stall", cpu_stall, 1);
      check("idle_misalign", misalign, 0);
      @(posedge clk); #1;
      for (int i = 0; i < TO_A; i++) begin
         bus_ready = (i == nlow);
         bus_rdata = (i == nlow) ? rd : $urandom;
         @(posedge clk); #1;
         if (i == nlow) break;
      end
      bus_ready = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      logic prev_req;
      int   stall_cnt;
      int   txn;
      exp_t e;
      prev_req  = 1'b0;
      stall_cnt = 0;
      txn       = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            q.delete();
            prev_req  = 1'b0;
            stall_cnt = 0;
            check("reset_busreq", bus_req, 0);
         end else begin
            if (cpu_stall) stall_cnt++;
            if (bus_req) begin
               if (q.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL unexpected_req: bus_req=1 addr=%h with no pending access", bus_addr);
               end else begin
                  check("req_addr", bus_addr, q[0].addr);
                  check("req_be", bus_be, q[0].be);
                  check("req_we", bus_we, q[0].we);
                  if (q[0].we) check("req_wdata", bus_wdata, q[0].wdata);
               end
            end else if (prev_req) begin
               if (q.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL unexpected_done: response with no pending access");
               end else begin
                  e = q.pop_front();
                  check("done_rdata", cpu_rdata, e.rdata);
                  check("done_err", bus_err, e.err);
                  check("done_stall_cycles", stall_cnt, e.stall);
                  txn++;
                  $display("[TB] txn %0d addr=%h we=%0d be=%b rdata=%h err=%0d stall=%0d",
                           txn, e.addr, e.we, e.be, cpu_rdata, bus_err, stall_cnt);
               end
               stall_cnt = 0;
            end else begin
               check("idle_rdata", cpu_rdata, 0);
               check("idle_err", bus_err, 0);
            end
            prev_req = bus_req;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int          kind, cnt;
      logic        re, we;
      logic [2:0]  t;
      logic [31:0] a;
      exp_t        e;

      reset = 1'b0;
      cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_dmtype = 0;
      bus_ready = 0; bus_rdata = 0;
      b_re = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_dmtype = 0; b_ready = 0; b_rdata = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_bus_req", bus_req, 0);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_bus_be", bus_be, 0);
      check("rst_bus_wdata", bus_wdata, 0);
      check("rst_bus_we", bus_we, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_bus_err", bus_err, 0);
      check("rst_cpu_stall", cpu_stall, 0);
      reset = 1'b1;

      // directed: word load, extensions, stores, misaligned, slow bus
      access(1, 0, 32'h104, 0, 3'd0, 0, 32'h80FF_1234);
      access(1, 0, 32'h107, 0, 3'd3, 0, 32'h80FF_1234);
      access(1, 0, 32'h107, 0, 3'd4, 0, 32'h80FF_1234);
      access(1, 0, 32'h106, 0, 3'd1, 0, 32'h80FF_1234);
      access(1, 0, 32'h104, 0, 3'd2, 0, 32'h80FF_1234);
      access(0, 1, 32'h102, 32'h1122_33AB, 3'd3, 0, 32'h5555_5555);
      access(0, 1, 32'h102, 32'h1122_33AB, 3'd1, 0, 32'h5555_5555);
      access(1, 0, 32'h101, 0, 3'd0, 0, 0);
      access(0, 1, 32'h103, 32'h1234_5678, 3'd1, 0, 0);
      access(1, 0, 32'h110, 0, 3'd0, 5, 32'hCAFE_F00D);
      access(0, 1, 32'h120, 32'hA5A5_0F0F, 3'd0, 0, 0);
      access(1, 0, 32'h120, 0, 3'd0, 0, 32'hA5A5_0F0F);
      access(1, 1, 32'h124, 32'h0BAD_CAFE, 3'd6, 1, 32'hFFFF_FFFF);
      access(1, 0, 32'h130, 0, 3'd0, 300, 32'h1111_1111);
      idle(1);

      for (int k = 0; k < 80; k++) begin
         kind = int'($urandom_range(0, 3));
         re   = (kind != 1);
         we   = (kind == 1) || (kind == 2);
         t    = 3'($urandom_range(0, 7));
         a    = 32'h1000 + ($urandom & 32'hFF);
         if ($urandom_range(0, 3) != 0) a = a - (a % size_of(t));
         access(re, we, a, $urandom, t, int'($urandom_range(0, 6)), $urandom);
         idle(int'($urandom_range(0, 2)));
      end

      // reset in the middle of REQ, then a late response that must be ignored
      @(posedge clk); #1;
      cpu_re = 1; cpu_we = 0; cpu_addr = 32'h108; cpu_dmtype = 3'd0; bus_ready = 0;
      e.addr = 32'h108; e.be = 4'hF; e.we = 0; e.wdata = 0; e.rdata = 0; e.err = 0; e.stall = 0;
      q.push_back(e);
      @(posedge clk); #1;
      @(posedge clk); #3;
      reset = 1'b0; cpu_re = 0;
      #1;
      check("async_busreq", bus_req, 0);
      check("async_stall", cpu_stall, 0);
      check("async_rdata", cpu_rdata, 0);
      @(posedge clk); #1;
      reset = 1'b1; bus_ready = 1; bus_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      check("post_reset_busreq", bus_req, 0);
      check("post_reset_rdata", cpu_rdata, 0);
      bus_ready = 0;
      access(1, 0, 32'h10C, 0, 3'd4, 0, 32'h0077_0000);
      idle(2);

      // short-timeout instance: abort after exactly TO_B REQ cycles
      @(posedge clk); #1;
      b_re = 1; b_addr = 32'h200; b_dmtype = 3'd0; b_ready = 0;
      @(posedge clk); #1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (!b_bus_req) break;
         cnt++;
         @(posedge clk); #1;
      end
      b_re = 0;
      check("to_req_cycles", cnt, TO_B);
      check("to_err", b_bus_err, 1);
      check("to_rdata", b_cpu_rdata, 0);
      check("to_stall", b_cpu_stall, 0);
      $display("[TB] timeout txn req_cycles=%0d err=%0d", cnt, b_bus_err);

      // ready on the very last allowed REQ cycle still completes normally
      @(posedge clk); #1;
      b_re = 1; b_addr = 32'h203; b_dmtype = 3'd3;
      @(posedge clk); #1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (!b_bus_req) break;
         cnt++;
         b_ready = (cnt == TO_B);
         b_rdata = (cnt == TO_B) ? 32'h9A00_0000 : $urandom;
         @(posedge clk); #1;
      end
      b_re = 0; b_ready = 0;
      check("last_ready_cycles", cnt, TO_B);
      check("last_ready_err", b_bus_err, 0);
      check("last_ready_rdata", b_cpu_rdata, load_m(32'h9A00_0000, 32'h203, 3'd3));
      $display("[TB] late-ready txn req_cycles=%0d rdata=%h err=%0d", cnt, b_cpu_rdata, b_bus_err);

      idle(3);
      check("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory access stage sitting directly downstream of the single-cycle RISC-V core's memory port (ALU address, store data, `mem_w`, `DMType`). It turns each load/store into a handshaked word-bus transaction toward data RAM/MMIO. It generates byte enables and lane-replicated store data, then extracts and sign/zero-extends load data. It stalls the core until the bus responds or a timeout expires, and flags misaligned accesses without touching the bus.

## Interface
- `TIMEOUT`, default 255: maximum REQ-state cycles without `bus_ready` before the access is aborted with `bus_err` (must be ≥1).
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cpu_re` in 1: load request from the core.
- `cpu_we` in 1: store request (`mem_w`); write wins if both `cpu_re` and `cpu_we` are high.
- `cpu_addr` in 32: byte address (ALU output).
- `cpu_wdata` in 32: store data (rs2).
- `cpu_dmtype` in 3: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned; 101–111 treated as word.
- `cpu_rdata` out 32: extended load result, valid in the DONE cycle.
- `cpu_stall` out 1: freeze core PC/regfile writes.
- `misalign` out 1: misaligned access detected, combinational in IDLE.
- `bus_err` out 1: timeout abort, high for the DONE cycle only.
- `bus_req` out 1: transaction valid.
- `bus_we` out 1: write transaction.
- `bus_addr` out 32: word-aligned address, `{cpu_addr[31:2],2'b00}`.
- `bus_be` out 4: byte enables, driven for loads and stores.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_rdata` in 32: read data, sampled with `bus_ready`.
- `bus_ready` in 1: transaction completes at this rising edge (MIO_ready).

## Operation
- Access = `cpu_re | cpu_we`. Misaligned = half with `addr[0]=1`, or word with `addr[1:0]!=0`.
- States are IDLE, REQ, DONE.
- **IDLE**
  - Access, aligned: `cpu_stall=1`; latch `addr`, `we`, `dmtype`, `be`, and `wdata` into bus registers; go to REQ.
  - Access, misaligned: `misalign=1`, `cpu_stall=0`, no bus activity, `cpu_rdata=0`; stay in IDLE.
  - No access: stay in IDLE with `cpu_stall=0`.
- **REQ**
  - `bus_req=1` and `cpu_stall=1`. Bus outputs are held stable.
  - `bus_ready=1`: capture `bus_rdata` (reads), clear the timeout counter, go to DONE.
  - Otherwise the counter increments. When it reaches `TIMEOUT-1` without ready, set the error flag, force the captured data to 0, and go to DONE.
- **DONE**
  - `bus_req=0`, `cpu_stall=0`, `cpu_rdata` valid, `bus_err` reflects the flag. The core retires the instruction at the end of this cycle.
  - Always return to IDLE. A back-to-back access is seen in IDLE on the next cycle.
- **Byte enables (by `addr[1:0]`)**
  - byte: `0001 << addr[1:0]`
  - half: `0011` (addr[1]=0) or `1100` (addr[1]=1)
  - word: `1111`
- **Store data**
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata` unchanged
- **Load extract** uses the latched `addr[1:0]` and `dmtype`.
  - byte lane = `rdata[8*a+7:8*a]`; half lane = `rdata[16*a1+15:16*a1]`.
  - Sign-extend for 000/001/011; zero-extend for 010/100.
  - Stores return `cpu_rdata=0`.
- **Reset (low)**
  - State returns to IDLE; all registers and outputs go to 0 immediately, including `bus_req` mid-REQ.
  - An in-flight bus response arriving after reset is ignored.

## Timing
- Minimum aligned access occupies 3 cycles (IDLE, REQ, DONE); `cpu_stall` is high for 2 of them.
- Latency = 3 + N cycles, where N = cycles `bus_ready` stays low in REQ.
- Timeout: REQ lasts exactly `TIMEOUT` cycles, then one DONE cycle with `bus_err=1`.
- `bus_*` outputs are registered and change only on the IDLE→REQ edge, on the REQ→DONE edge (`bus_req` falls), or on reset.
- `cpu_stall` and `misalign` are combinational from state and CPU inputs in IDLE.
- `cpu_rdata` and `bus_err` are registered and valid throughout DONE; they are 0 in other states.
- `bus_ready` is ignored outside REQ.

## Test plan
- **Word load:** lw `addr=0x104`, `bus_ready` on the first REQ cycle, `bus_rdata=0x80FF_1234` → `bus_addr=0x104`, `bus_be=1111`, stall for 2 cycles, `cpu_rdata=0x80FF_1234` in DONE.
- **Byte/half extension:** `bus_rdata=0x80FF_1234`.
  - lb `0x107` → `be=1000`, rdata `0xFFFF_FF80`.
  - lbu `0x107` → `0x0000_0080`.
  - lh `0x106` → `0xFFFF_80FF`.
  - lhu `0x104` → `0x0000_1234`.
- **Stores:**
  - sb `0x102`, `wdata=0x1122_33AB` → `be=0100`, `bus_wdata=0xABAB_ABAB`, `bus_we=1`.
  - sh `0x102` → `be=1100`, `bus_wdata=0x33AB_33AB`.
- **Misaligned:** lw `0x101`, then sh `0x103` → `misalign=1`, `bus_req` stays 0, `cpu_stall=0`.
- **Slow bus and timeout:**
  - Ready after 5 low cycles → stall 7 cycles, `bus_err=0`.
  - `TIMEOUT=4` with ready never asserted → REQ for 4 cycles, then DONE with `bus_err=1`, `cpu_rdata=0`.
- **Reset and back-to-back:**
  - Assert `reset=0` mid-REQ → `bus_req` drops asynchronously and state is IDLE after release.
  - Consecutive sw then lw → two separate 3-cycle transactions, no lost or merged access.
